// File: rtl/data_interconnect_ctrl.sv
// data_interconnect_ctrl
// Run-time sequencer for the data_interconnect_0 mode switch. It accepts
// commands {mode, packet count}. It changes `mode` only while neither the
// f nor the h stream has an open packet. Its f/h enables are ANDed into
// the upstream tvalids, and it counts f-stream packets (tlast beats) until
// the commanded count is reached.
//
// Ports
//   clk, rst_n                    clock (rising edge), async active-low reset
//   cmd_valid/cmd_ready           command handshake (ready only in IDLE)
//   cmd_mode, cmd_pkts            target mode and f-packet count of a command
//   f_tvalid/f_tready/f_tlast     observed f stream (post-gating)
//   h_tvalid/h_tready/h_tlast     observed h stream (post-gating)
//   mode                          registered mode to the interconnect
//   f_en, h_en                    registered upstream tvalid enables
//   busy                          sequencer not in IDLE
//   done                          one-cycle pulse at command completion
//   pkt_cnt                       f packets completed in the current command
module data_interconnect_ctrl #(
  parameter int CNT_W      = 16,
  parameter int SETTLE_CYC = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_mode,
  input  logic [CNT_W-1:0] cmd_pkts,
  input  logic             f_tvalid,
  input  logic             f_tready,
  input  logic             f_tlast,
  input  logic             h_tvalid,
  input  logic             h_tready,
  input  logic             h_tlast,
  output logic             mode,
  output logic             f_en,
  output logic             h_en,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pkt_cnt
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SWITCH = 3'd1;
  localparam logic [2:0] ST_RUN    = 3'd2;
  localparam logic [2:0] ST_DRAIN  = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  localparam int               SET_W       = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYC - 1);

  logic [2:0]       state_reg, state_next;
  logic             mode_reg, mode_next;
  logic             tgt_mode_reg, tgt_mode_next;
  logic [CNT_W-1:0] pkts_reg, pkts_next;
  logic [CNT_W-1:0] pkt_cnt_reg, pkt_cnt_next;
  logic             f_en_reg, f_en_next;
  logic             h_en_reg, h_en_next;
  logic             done_reg, done_next;
  logic             f_open_reg, f_open_next;
  logic             h_open_reg, h_open_next;
  // Set once the new mode has been written inside SWITCH; from then on the
  // state only counts settle cycles.
  logic             mode_set_reg, mode_set_next;
  logic [SET_W-1:0] settle_reg, settle_next;

  logic f_beat, h_beat, accept;

  assign f_beat    = f_tvalid & f_tready;
  assign h_beat    = h_tvalid & h_tready;
  assign cmd_ready = (state_reg == ST_IDLE);
  assign accept    = cmd_valid & cmd_ready;

  always_comb begin
    state_next    = state_reg;
    mode_next     = mode_reg;
    tgt_mode_next = tgt_mode_reg;
    pkts_next     = pkts_reg;
    pkt_cnt_next  = pkt_cnt_reg;
    f_en_next     = f_en_reg;
    h_en_next     = h_en_reg;
    done_next     = 1'b0;
    mode_set_next = mode_set_reg;
    settle_next   = settle_reg;

    // Open-packet tracking runs in every state, independent of the FSM.
    f_open_next = f_beat ? ~f_tlast : f_open_reg;
    h_open_next = h_beat ? ~h_tlast : h_open_reg;

    case (state_reg)
      ST_IDLE: begin
        f_en_next = 1'b0;
        h_en_next = 1'b0;
        if (accept) begin
          tgt_mode_next = cmd_mode;
          pkts_next     = cmd_pkts;
          pkt_cnt_next  = '0;
          mode_set_next = 1'b0;
          settle_next   = '0;
          if (cmd_mode != mode_reg) begin
            state_next = ST_SWITCH;
          end else if (cmd_pkts == '0) begin
            state_next = ST_DONE;
            done_next  = 1'b1;
          end else begin
            // Enables are registered: raise them on the accept edge so they
            // are already high in the first RUN cycle.
            state_next = ST_RUN;
            f_en_next  = 1'b1;
            h_en_next  = 1'b1;
          end
        end
      end

      ST_SWITCH: begin
        f_en_next = 1'b0;
        h_en_next = 1'b0;
        if (!mode_set_reg) begin
          if (!f_open_reg && !h_open_reg) begin
            mode_next     = tgt_mode_reg;
            mode_set_next = 1'b1;
            settle_next   = '0;
          end
        end else if (settle_reg == SETTLE_LAST) begin
          if (pkts_reg == '0) begin
            state_next = ST_DONE;
            done_next  = 1'b1;
          end else begin
            state_next = ST_RUN;
            f_en_next  = 1'b1;
            h_en_next  = 1'b1;
          end
        end else begin
          settle_next = settle_reg + 1'b1;
        end
      end

      ST_RUN: begin
        if (f_beat && f_tlast) begin
          pkt_cnt_next = pkt_cnt_reg + 1'b1;
          // Drop f_en on the same edge the final tlast is counted so no
          // further f beat gets through.
          if (pkt_cnt_reg + 1'b1 == pkts_reg) begin
            f_en_next  = 1'b0;
            state_next = ST_DRAIN;
          end
        end
      end

      ST_DRAIN: begin
        f_en_next = 1'b0;
        if (!h_open_reg) begin
          h_en_next  = 1'b0;
          state_next = ST_DONE;
          done_next  = 1'b1;
        end
      end

      ST_DONE: begin
        f_en_next  = 1'b0;
        h_en_next  = 1'b0;
        state_next = ST_IDLE;
      end

      default: begin
        state_next = ST_IDLE;
        f_en_next  = 1'b0;
        h_en_next  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      mode_reg     <= 1'b0;
      tgt_mode_reg <= 1'b0;
      pkts_reg     <= '0;
      pkt_cnt_reg  <= '0;
      f_en_reg     <= 1'b0;
      h_en_reg     <= 1'b0;
      done_reg     <= 1'b0;
      f_open_reg   <= 1'b0;
      h_open_reg   <= 1'b0;
      mode_set_reg <= 1'b0;
      settle_reg   <= '0;
    end else begin
      state_reg    <= state_next;
      mode_reg     <= mode_next;
      tgt_mode_reg <= tgt_mode_next;
      pkts_reg     <= pkts_next;
      pkt_cnt_reg  <= pkt_cnt_next;
      f_en_reg     <= f_en_next;
      h_en_reg     <= h_en_next;
      done_reg     <= done_next;
      f_open_reg   <= f_open_next;
      h_open_reg   <= h_open_next;
      mode_set_reg <= mode_set_next;
      settle_reg   <= settle_next;
    end
  end

  assign mode    = mode_reg;
  assign f_en    = f_en_reg;
  assign h_en    = h_en_reg;
  assign busy    = (state_reg != ST_IDLE);
  assign done    = done_reg;
  assign pkt_cnt = pkt_cnt_reg;

endmodule

// File: tb/tb_data_interconnect_ctrl.sv
// Directed bench for data_interconnect_ctrl. Each command pushes its expected
// completion {pkt_cnt, mode} onto a scoreboard queue; a monitor pops and
// compares on every done pulse. Cycle-level checks sit inline in the stimulus.
module tb_data_interconnect_ctrl;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_mode;
  logic [CNT_W-1:0] cmd_pkts;
  logic             f_tvalid, f_tready, f_tlast;
  logic             h_tvalid, h_tready, h_tlast;
  logic             mode, f_en, h_en, busy, done;
  logic [CNT_W-1:0] pkt_cnt;

  typedef struct {
    logic [CNT_W-1:0] pkts;
    logic             mode;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_done  = 0;

  data_interconnect_ctrl #(.CNT_W(CNT_W), .SETTLE_CYC(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_mode (cmd_mode),
    .cmd_pkts (cmd_pkts),
    .f_tvalid (f_tvalid),
    .f_tready (f_tready),
    .f_tlast  (f_tlast),
    .h_tvalid (h_tvalid),
    .h_tready (h_tready),
    .h_tlast  (h_tlast),
    .mode     (mode),
    .f_en     (f_en),
    .h_en     (h_en),
    .busy     (busy),
    .done     (done),
    .pkt_cnt  (pkt_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One cycle of stream activity; ready is always high.
  task automatic drive(input logic fv, input logic fl, input logic hv, input logic hl);
    f_tvalid = fv; f_tready = 1'b1; f_tlast = fl;
    h_tvalid = hv; h_tready = 1'b1; h_tlast = hl;
    tick();
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic send_cmd(input logic m, input logic [CNT_W-1:0] p);
    exp_t e;
    cmd_valid = 1'b1; cmd_mode = m; cmd_pkts = p;
    e.pkts = p; e.mode = m;
    sb_q.push_back(e);
  endtask

  // Scoreboard monitor: one line per completed command.
  always @(negedge clk) begin
    if (rst_n && done) begin
      exp_t e;
      n_done++;
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_done", 32'(done), 32'd0);
      end else begin
        e = sb_q.pop_front();
        $display("[TB] done: pkt_cnt=%0d mode=%0d (expected %0d/%0d)", pkt_cnt, mode, e.pkts, e.mode);
        chk("sb_pkt_cnt", 32'(pkt_cnt), 32'(e.pkts));
        chk("sb_mode", 32'(mode), 32'(e.mode));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_mode = 1'b0; cmd_pkts = '0;
    f_tvalid = 1'b0; f_tready = 1'b1; f_tlast = 1'b0;
    h_tvalid = 1'b0; h_tready = 1'b1; h_tlast = 1'b0;
    tick(); tick();
    chk("rst_mode", 32'(mode), 0);
    chk("rst_f_en", 32'(f_en), 0);
    chk("rst_h_en", 32'(h_en), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_pkt_cnt", 32'(pkt_cnt), 0);
    chk("rst_cmd_ready", 32'(cmd_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    rst_n = 1'b1;
    tick();

    // 1: mode switch 0->1, 3 packets of 4 beats
    send_cmd(1'b1, 16'd3);
    tick();
    cmd_valid = 1'b0;
    chk("t1_busy", 32'(busy), 1);
    chk("t1_cmd_ready", 32'(cmd_ready), 0);
    chk("t1_mode_hold", 32'(mode), 0);
    idle();
    chk("t1_mode_toggle", 32'(mode), 1);
    chk("t1_f_en_settle0", 32'(f_en), 0);
    idle();
    chk("t1_f_en_settle1", 32'(f_en), 0);
    idle();
    chk("t1_f_en_rise", 32'(f_en), 1);
    chk("t1_h_en_rise", 32'(h_en), 1);
    for (int p = 0; p < 3; p++) begin
      for (int b = 0; b < 4; b++) begin
        drive(1'b1, (b == 3), 1'b0, 1'b0);
      end
      chk("t1_pkt_cnt", 32'(pkt_cnt), 32'(p + 1));
      chk("t1_f_en_after_pkt", 32'(f_en), (p < 2) ? 32'd1 : 32'd0);
    end
    idle();
    chk("t1_done", 32'(done), 1);
    idle();
    chk("t1_done_clear", 32'(done), 0);
    chk("t1_ready_back", 32'(cmd_ready), 1);
    chk("t1_pkt_cnt_hold", 32'(pkt_cnt), 3);

    // 2: same mode, h packet open when f count met
    send_cmd(1'b1, 16'd2);
    tick();
    cmd_valid = 1'b0;
    chk("t2_f_en_fast", 32'(f_en), 1);
    chk("t2_mode_stays", 32'(mode), 1);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    chk("t2_pkt_cnt1", 32'(pkt_cnt), 1);
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    chk("t2_drain_f_en", 32'(f_en), 0);
    chk("t2_drain_h_en", 32'(h_en), 1);
    chk("t2_pkt_cnt2", 32'(pkt_cnt), 2);
    for (int i = 0; i < 4; i++) idle();
    chk("t2_drain_wait_done", 32'(done), 0);
    chk("t2_drain_wait_h_en", 32'(h_en), 1);
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    chk("t2_hlast_no_done_yet", 32'(done), 0);
    idle();
    chk("t2_done", 32'(done), 1);
    chk("t2_h_en_off", 32'(h_en), 0);
    idle();

    // 3: switch back to mode 0 with zero packets
    send_cmd(1'b0, 16'd0);
    tick();
    cmd_valid = 1'b0;
    chk("t3_mode_hold", 32'(mode), 1);
    idle();
    chk("t3_mode_toggle", 32'(mode), 0);
    idle();
    chk("t3_settle_no_done", 32'(done), 0);
    chk("t3_settle_f_en", 32'(f_en), 0);
    idle();
    chk("t3_done", 32'(done), 1);
    chk("t3_f_en_never", 32'(f_en), 0);
    idle();
    chk("t3_ready", 32'(cmd_ready), 1);

    // 4: cmd_valid held through RUN; second command right after done
    send_cmd(1'b0, 16'd1);
    tick();
    chk("t4_f_en", 32'(f_en), 1);
    cmd_pkts = 16'd0;
    begin
      exp_t e2;
      e2.pkts = 16'd0; e2.mode = 1'b0;
      sb_q.push_back(e2);
    end
    idle(); idle();
    chk("t4_busy_ignore", 32'(cmd_ready), 0);
    chk("t4_pkt_cnt0", 32'(pkt_cnt), 0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    chk("t4_pkt_cnt1", 32'(pkt_cnt), 1);
    idle();
    chk("t4_done1", 32'(done), 1);
    chk("t4_ready_in_done", 32'(cmd_ready), 0);
    idle();
    chk("t4_ready_idle", 32'(cmd_ready), 1);
    tick();
    cmd_valid = 1'b0;
    chk("t4_done2", 32'(done), 1);
    chk("t4_pkt_cnt_cleared", 32'(pkt_cnt), 0);
    idle();

    // 5: reset mid-RUN with an f packet open
    send_cmd(1'b1, 16'd2);
    tick();
    cmd_valid = 1'b0;
    idle(); idle(); idle();
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    chk("t5_pkt_cnt1", 32'(pkt_cnt), 1);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    f_tvalid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_async_mode", 32'(mode), 0);
    chk("t5_async_f_en", 32'(f_en), 0);
    chk("t5_async_h_en", 32'(h_en), 0);
    chk("t5_async_pkt_cnt", 32'(pkt_cnt), 0);
    chk("t5_async_ready", 32'(cmd_ready), 1);
    sb_q.delete();
    tick();
    rst_n = 1'b1;
    tick();

    // 6: switch must wait for an open h packet (f_open was cleared by reset)
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    send_cmd(1'b1, 16'd0);
    idle();
    cmd_valid = 1'b0;
    idle();
    chk("t6_blocked0", 32'(mode), 0);
    idle();
    chk("t6_blocked1", 32'(mode), 0);
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    chk("t6_blocked2", 32'(mode), 0);
    idle();
    chk("t6_mode_toggle", 32'(mode), 1);
    idle();
    chk("t6_settle", 32'(done), 0);
    idle();
    chk("t6_done", 32'(done), 1);
    chk("t6_f_en_never", 32'(f_en), 0);
    idle(); idle();

    chk("sb_empty", 32'(sb_q.size()), 0);
    chk("done_count", 32'(n_done), 6);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
